seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. Latches a 32-bit display word, steps a 3-bit digit index at a programmable rate, and drives the active-low anode enables. Its `data_32` and `selector` outputs feed the nibble selector directly; the selected nibble then goes to the hex-to-segment decoder. Display-word updates are applied only at frame boundaries, so a displayed word never mixes old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Purpose:
//   Time-multiplexing scan controller for an 8-digit seven-segment display.
//   A prescaler divides the system clock down to one digit slot every
//   SCAN_DIV cycles. A 3-bit digit index walks 0..7 through the slots. The
//   active-low anode enables and the decimal point are driven from registers
//   so that they change on the same edge as the digit index.
//   New display words are captured into a shadow register and are promoted to
//   the displayed word only at the end of digit 7's slot. Because of this, a
//   single frame never shows a mix of old and new digits.
//
// Parameters:
//   SCAN_DIV    clock cycles per digit slot (legal range is 2 and above)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   enable      1 = display lit, 0 = all anodes off (scanning continues)
//   load        one-cycle request to capture data_in
//   data_in     new display word, nibble i is digit i
//   blank_lz    1 = suppress leading-zero digits
//   dp_mask     decimal-point request per digit, active-high
//   data_32     currently displayed word (to the nibble selector)
//   selector    current digit index 0..7 (to the nibble selector)
//   an          anode enables, active-low, bit i = digit i
//   dp          decimal point for the current digit, active-low
//   pending     a captured word is waiting for the next frame boundary
//   frame_done  one-cycle pulse after digit 7's slot ends
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [31:0] data_32,
  output logic [2:0]  selector,
  output logic [7:0]  an,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);

  // The guard keeps the counter at least one bit wide even if the module is
  // misconfigured.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pcnt_next;
  logic             tick;
  logic             boundary;
  logic [2:0]       selector_next;

  logic [31:0]      shadow;
  logic [31:0]      shadow_next;
  logic [31:0]      data_next;
  logic             pending_next;

  logic [7:0]       blank_mask;
  logic             digit_off;
  logic [7:0]       an_next;
  logic             dp_next;

  // Prescaler and digit index. The index moves only on a tick. The 3-bit
  // add wraps 7 back to 0 on its own.
  always_comb begin
    tick          = (pcnt == PCNT_LAST);
    boundary      = tick && (selector == 3'd7);
    pcnt_next     = tick ? '0 : pcnt + CNT_W'(1);
    selector_next = tick ? selector + 3'd1 : selector;
  end

  // Display-word update path.
  // On a frame boundary, a load that arrives in the same cycle takes priority
  // over any older shadow value. The shadow value is replaced as well, so a
  // stale word can never come back later.
  // Away from a boundary, a load only updates the shadow register. When
  // several loads arrive before a boundary, the last one is kept.
  always_comb begin
    data_next    = data_32;
    shadow_next  = shadow;
    pending_next = pending;
    if (boundary) begin
      pending_next = 1'b0;
      if (load) begin
        data_next   = data_in;
        shadow_next = data_in;
      end else if (pending) begin
        data_next = shadow;
      end
    end else if (load) begin
      shadow_next  = data_in;
      pending_next = 1'b1;
    end
  end

  // Leading-zero blank mask, taken from the word that is on display now.
  // The scan runs from the top nibble downward. A digit is blanked only while
  // every nibble from that digit up to nibble 7 is zero. Digit 0 always
  // stays lit, so a value of zero still shows a single "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = 7; i >= 1; i--) begin
      upper_zero    = upper_zero & (data_32[4*i +: 4] == 4'h0);
      blank_mask[i] = blank_lz & upper_zero;
    end
  end

  // Anode and decimal-point values come from the digit index that will be
  // current after this edge. When they are registered, they line up with
  // the selector that is driving the nibble selector.
  always_comb begin
    digit_off = !enable || blank_mask[selector_next];
    an_next   = 8'hFF;
    dp_next   = 1'b1;
    if (!digit_off) begin
      an_next = ~(8'b1 << selector_next);
      dp_next = ~dp_mask[selector_next];
    end
  end

  // Timebase state: the prescaler count and the digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt     <= '0;
      selector <= 3'd0;
    end else begin
      pcnt     <= pcnt_next;
      selector <= selector_next;
    end
  end

  // Displayed word, shadow word and the pending flag. A load in the reset
  // cycle is dropped, because reset wins over every other condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_32 <= 32'h0;
      shadow  <= 32'h0;
      pending <= 1'b0;
    end else begin
      data_32 <= data_next;
      shadow  <= shadow_next;
      pending <= pending_next;
    end
  end

  // Registered display drive and the frame pulse. During reset the display
  // is dark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      dp         <= dp_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Purpose:
//   Self-checking bench for seg7_scan_ctrl with SCAN_DIV = 4.
//   A reference model tracks the display from the number of clock edges
//   since reset release. For example, slot = cycles / SCAN_DIV and
//   digit = slot mod 8. The model also follows the load rules.
//   A table of directed records walks through reset, scanning, tear-free
//   loading, load on the boundary, leading-zero blanking, enable and the
//   decimal point. A randomized phase follows the table.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [31:0] data_in;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [31:0] data_32;
  logic [2:0]  selector;
  logic [7:0]  an;
  logic        dp;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cyc;
  logic [31:0] m_data;
  logic [31:0] m_shadow;
  logic        m_pending;
  logic [7:0]  m_an;
  logic        m_dp;
  logic        m_fd;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        ld;
    logic [31:0] din;
    logic        blz;
    logic [7:0]  dpm;
    int          n;
    logic [2:0]  sel;
    logic [7:0]  an;
    logic        dp;
    logic [31:0] data;
    logic        pend;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .data_32    (data_32),
    .selector   (selector),
    .an         (an),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Compares one value and records the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual,
               required, $time);
    end
  endtask

  // Advances the model across one clock edge, using the inputs that are
  // present at that edge.
  task automatic model_edge();
    int   nxt;
    logic boundary;
    logic off;
    if (!rst_n) begin
      m_cyc     = 0;
      m_data    = 32'h0;
      m_shadow  = 32'h0;
      m_pending = 1'b0;
      m_an      = 8'hFF;
      m_dp      = 1'b1;
      m_fd      = 1'b0;
    end else begin
      boundary = (m_cyc % FRAME) == FRAME - 1;
      nxt      = ((m_cyc + 1) / SCAN_DIV) % 8;
      off      = !enable ||
                 (blank_lz && nxt != 0 && (m_data >> (4 * nxt)) == 32'h0);
      m_an     = off ? 8'hFF : ~(8'h01 << nxt);
      m_dp     = off | ~dp_mask[nxt];
      m_fd     = boundary;
      if (boundary) begin
        if (load) m_data = data_in;
        else if (m_pending) m_data = m_shadow;
        m_pending = 1'b0;
      end else if (load) begin
        m_shadow  = data_in;
        m_pending = 1'b1;
      end
      m_cyc++;
    end
  endtask

  // Drives one cycle of inputs, clocks the DUT and the model together, and
  // compares every output 1 ns after the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic ld,
                               input logic [31:0] din, input logic blz,
                               input logic [7:0] dpm);
    rst_n    = r;
    enable   = en;
    load     = ld;
    data_in  = din;
    blank_lz = blz;
    dp_mask  = dpm;
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("model.selector", 32'(selector), 32'((m_cyc / SCAN_DIV) % 8));
    checkOutput("model.an", 32'(an), 32'(m_an));
    checkOutput("model.dp", 32'(dp), 32'(m_dp));
    checkOutput("model.data_32", data_32, m_data);
    checkOutput("model.pending", 32'(pending), 32'(m_pending));
    checkOutput("model.frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  initial begin
    // rst en ld din blz dpm n | sel an dp data pend fd
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,32'hDEADBEEF,1'b0,8'hFF, 3, 3'd0,8'hFF,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'h87654321,1'b0,8'h00, 1, 3'd0,8'hFE,1'b1,32'h0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00,30, 3'd7,8'h7F,1'b1,32'h0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00, 1, 3'd0,8'hFE,1'b1,32'h87654321,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00, 4, 3'd1,8'hFD,1'b1,32'h87654321,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00,28, 3'd0,8'hFE,1'b1,32'h87654321,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00,12, 3'd3,8'hF7,1'b1,32'h87654321,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'hAAAAAAAA,1'b0,8'h00, 1, 3'd3,8'hF7,1'b1,32'h87654321,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00, 7, 3'd5,8'hDF,1'b1,32'h87654321,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'h55555555,1'b0,8'h00, 1, 3'd5,8'hDF,1'b1,32'h87654321,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00,10, 3'd7,8'h7F,1'b1,32'h87654321,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00, 1, 3'd0,8'hFE,1'b1,32'h55555555,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'hCAFEF00D,1'b0,8'h00, 1, 3'd0,8'hFE,1'b1,32'h55555555,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h00,30, 3'd7,8'h7F,1'b1,32'h55555555,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'h00001234,1'b0,8'h00, 1, 3'd0,8'hFE,1'b1,32'h00001234,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'h000000F0,1'b1,8'h00, 1, 3'd0,8'hFE,1'b1,32'h00001234,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00,30, 3'd7,8'hFF,1'b1,32'h00001234,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00, 1, 3'd0,8'hFE,1'b1,32'h000000F0,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00, 4, 3'd1,8'hFD,1'b1,32'h000000F0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00, 4, 3'd2,8'hFF,1'b1,32'h000000F0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00,20, 3'd7,8'hFF,1'b1,32'h000000F0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'h0,1'b1,8'h00, 1, 3'd7,8'hFF,1'b1,32'h000000F0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00, 3, 3'd0,8'hFE,1'b1,32'h0,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b1,8'h00, 4, 3'd1,8'hFF,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h04, 4, 3'd2,8'hFB,1'b0,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,32'h0,1'b0,8'h04, 1, 3'd2,8'hFF,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,32'h0,1'b0,8'h04, 7, 3'd4,8'hFF,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h04, 1, 3'd4,8'hEF,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h04,23, 3'd2,8'hFB,1'b0,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h04, 4, 3'd3,8'hF7,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b1,32'h12345678,1'b0,8'h04, 1, 3'd3,8'hF7,1'b1,32'h0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,32'hFFFFFFFF,1'b0,8'h04, 1, 3'd0,8'hFF,1'b1,32'h0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b1,1'b0,32'h0,1'b0,8'h04, 1, 3'd0,8'hFE,1'b1,32'h0,1'b0,1'b0});

    // Directed table: load is asserted only on the first cycle of each record.
    for (int v = 0; v < vecs.size(); v++) begin
      for (int k = 0; k < vecs[v].n; k++)
        applyStimulus(vecs[v].rst_n, vecs[v].en, vecs[v].ld && (k == 0),
                      vecs[v].din, vecs[v].blz, vecs[v].dpm);
      checkOutput($sformatf("vec%0d.selector", v), 32'(selector), 32'(vecs[v].sel));
      checkOutput($sformatf("vec%0d.an", v), 32'(an), 32'(vecs[v].an));
      checkOutput($sformatf("vec%0d.dp", v), 32'(dp), 32'(vecs[v].dp));
      checkOutput($sformatf("vec%0d.data_32", v), data_32, vecs[v].data);
      checkOutput($sformatf("vec%0d.pending", v), 32'(pending), 32'(vecs[v].pend));
      checkOutput($sformatf("vec%0d.frame_done", v), 32'(frame_done), 32'(vecs[v].fd));
    end

    // Randomized phase: occasional resets, sparse loads, words with random
    // leading zeros, and random enable, blanking and decimal points.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] d;
      int          lz;
      d  = $urandom;
      lz = $urandom_range(0, 8);
      d  = (lz == 8) ? 32'h0 : (d >> (4 * lz));
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 15) == 0), d, 1'($urandom_range(0, 1)),
                    8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
